// File: rtl/sim_run_ctrl_pkg.sv
// Shared types and default addresses for the simulation run controller.
package sim_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT
    } run_state_e;

    localparam logic [31:0] DEF_TOHOST_ADDR  = 32'h0000_1000;
    localparam logic [31:0] DEF_CONSOLE_ADDR = 32'h0000_1004;

    // Wide enough for the largest supported RESET_CYCLES (255).
    localparam int HOLD_CNT_W = 8;

endpackage

// File: rtl/sim_run_ctrl_if.sv
// CPU data-bus write port plus console character stream.
interface sim_run_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              con_valid;
    logic [7:0]        con_data;
    logic              con_ready;
    logic              con_overflow;

    // master: the CPU side plus the console sink; slave: the run controller.
    modport master (
        output mem_we, mem_addr, mem_wdata, con_ready,
        input  con_valid, con_data, con_overflow
    );

    modport slave (
        input  mem_we, mem_addr, mem_wdata, con_ready,
        output con_valid, con_data, con_overflow
    );

endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with a sticky overflow flag.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             empty, full, pop, wr_en;

    // Extra pointer MSB distinguishes full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign valid = !empty;
    assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign pop   = valid && pop_ready;
    // A simultaneous pop frees the slot, so a push while full still lands.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (push && !wr_en) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/sim_run_ctrl.sv
// Holds the CPU in reset, runs it, watches the tohost mailbox and timeout,
// and buffers console characters written by the CPU.
module sim_run_ctrl
    import sim_run_ctrl_pkg::*;
#(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(DEF_TOHOST_ADDR),
    parameter logic [ADDR_W-1:0] CONSOLE_ADDR   = ADDR_W'(DEF_CONSOLE_ADDR),
    parameter int                RESET_CYCLES   = 4,
    parameter int                TIMEOUT_CYCLES = 20000,
    parameter int                CNT_W          = 32,
    parameter int                CON_DEPTH      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    sim_run_ctrl_if.slave     bus,
    output logic              cpu_rst,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [DATA_W-2:0] exit_code
);

    run_state_e            state_q, state_d;
    logic [HOLD_CNT_W-1:0] hold_cnt;
    logic                  term_wr, con_wr, to_hit;

    assign term_wr = bus.mem_we && (bus.mem_addr == TOHOST_ADDR) && bus.mem_wdata[0];
    assign con_wr  = (state_q == ST_RUN) && bus.mem_we && (bus.mem_addr == CONSOLE_ADDR);
    assign to_hit  = (TIMEOUT_CYCLES != 0) && (cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_HOLD: if (hold_cnt == HOLD_CNT_W'(RESET_CYCLES - 1)) state_d = ST_RUN;
            // A terminating write beats a coincident timeout.
            ST_RUN: begin
                if (term_wr)     state_d = ST_DONE;
                else if (to_hit) state_d = ST_TIMEOUT;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_HOLD;
            hold_cnt  <= '0;
            cycle_cnt <= '0;
            exit_code <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_HOLD) hold_cnt <= hold_cnt + 1'b1;
            if (state_q == ST_RUN) begin
                if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
                if (term_wr)         exit_code <= bus.mem_wdata[DATA_W-1:1];
            end
        end
    end

    assign cpu_rst = (state_q != ST_RUN);
    assign done    = (state_q == ST_DONE) || (state_q == ST_TIMEOUT);
    assign pass    = (state_q == ST_DONE) && (exit_code == '0);
    assign timeout = (state_q == ST_TIMEOUT);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (CON_DEPTH)
    ) u_con_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (con_wr),
        .push_data (bus.mem_wdata[7:0]),
        .pop_ready (bus.con_ready),
        .valid     (bus.con_valid),
        .head      (bus.con_data),
        .overflow  (bus.con_overflow)
    );

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Scoreboard bench for sim_run_ctrl: default instance plus a 50-cycle timeout instance.
module tb_sim_run_ctrl;

    localparam logic [31:0] TOHOST  = 32'h0000_1000;
    localparam logic [31:0] CONSOLE = 32'h0000_1004;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_rst0, done0, pass0, timeout0;
    logic        cpu_rst1, done1, pass1, timeout1;
    logic [31:0] cycle_cnt0, cycle_cnt1;
    logic [30:0] exit_code0, exit_code1;

    int          checks = 0;
    int          errors = 0;
    int          pops   = 0;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    sim_run_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    sim_run_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    sim_run_ctrl u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .cpu_rst(cpu_rst0), .cycle_cnt(cycle_cnt0),
        .done(done0), .pass(pass0), .timeout(timeout0), .exit_code(exit_code0)
    );

    sim_run_ctrl #(.TIMEOUT_CYCLES(50)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .cpu_rst(cpu_rst1), .cycle_cnt(cycle_cnt1),
        .done(done1), .pass(pass1), .timeout(timeout1), .exit_code(exit_code1)
    );

    task automatic idle_bus();
        bus0.mem_we = 1'b0; bus0.mem_addr = '0; bus0.mem_wdata = '0;
        bus1.mem_we = 1'b0; bus1.mem_addr = '0; bus1.mem_wdata = '0;
    endtask

    // Checks any console handshake about to happen, then advances one clock.
    task automatic tick();
        logic [7:0] exp;
        #1;
        if (bus0.con_valid && bus0.con_ready) begin
            checks++;
            pops++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL con_pop_unexpected: got %0h want none", bus0.con_data);
            end else begin
                exp = exp_q.pop_front();
                if (bus0.con_data !== exp) begin
                    errors++;
                    $display("FAIL con_data: got %0h want %0h", bus0.con_data, exp);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_bus();
        bus0.con_ready = 1'b0;
        bus1.con_ready = 1'b0;
        exp_q.delete();
        pops = 0;
        repeat (2) @(negedge clk);
    endtask

    // Releases reset and counts sampled cycles with cpu_rst high until RUN.
    task automatic release_run(output int hold);
        hold = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!cpu_rst0) break;
            hold++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int hold;
        apply_reset();
        #1;
        checks++; if (cpu_rst0 !== 1'b1) begin errors++; $display("FAIL rst_cpu_rst: got %b want 1", cpu_rst0); end
        checks++; if (cycle_cnt0 !== 32'd0) begin errors++; $display("FAIL rst_cycle_cnt: got %0d want 0", cycle_cnt0); end
        checks++; if ({done0, pass0, timeout0} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {done0, pass0, timeout0}); end
        checks++; if (exit_code0 !== 31'd0) begin errors++; $display("FAIL rst_exit_code: got %0h want 0", exit_code0); end
        checks++; if ({bus0.con_valid, bus0.con_overflow} !== 2'b00) begin errors++; $display("FAIL rst_con_flags: got %b want 00", {bus0.con_valid, bus0.con_overflow}); end
        checks++; if (bus0.con_data !== 8'd0) begin errors++; $display("FAIL rst_con_data: got %0h want 0", bus0.con_data); end
        release_run(hold);
        checks++; if (hold !== 4) begin errors++; $display("FAIL hold_cycles: got %0d want 4", hold); end
        checks++; if (cycle_cnt0 !== 32'd0) begin errors++; $display("FAIL run_start_cnt: got %0d want 0", cycle_cnt0); end
        tick(); tick();
        checks++; if (cycle_cnt0 !== 32'd2) begin errors++; $display("FAIL run_count: got %0d want 2", cycle_cnt0); end
    endtask

    task automatic test_pass();
        int hold;
        apply_reset();
        release_run(hold);
        for (int i = 0; i < 200 && cycle_cnt0 != 32'd100; i++) tick();
        checks++; if (cycle_cnt0 !== 32'd100) begin errors++; $display("FAIL pass_reach_100: got %0d want 100", cycle_cnt0); end
        bus0.mem_we = 1'b1; bus0.mem_addr = TOHOST; bus0.mem_wdata = 32'h1;
        tick();
        idle_bus();
        checks++; if ({done0, pass0, timeout0, cpu_rst0} !== 4'b1101) begin errors++; $display("FAIL pass_flags: got %b want 1101", {done0, pass0, timeout0, cpu_rst0}); end
        checks++; if (exit_code0 !== 31'd0) begin errors++; $display("FAIL pass_exit_code: got %0h want 0", exit_code0); end
        checks++; if (cycle_cnt0 !== 32'd101) begin errors++; $display("FAIL pass_cnt: got %0d want 101", cycle_cnt0); end
        // Writes after termination must change nothing.
        bus0.mem_we = 1'b1; bus0.mem_addr = TOHOST; bus0.mem_wdata = 32'h7;
        tick();
        bus0.mem_addr = CONSOLE; bus0.mem_wdata = 32'h41;
        tick();
        idle_bus();
        tick(); tick();
        checks++; if (exit_code0 !== 31'd0 || pass0 !== 1'b1) begin errors++; $display("FAIL done_terminal: got exit %0h pass %b want 0 1", exit_code0, pass0); end
        checks++; if (cycle_cnt0 !== 32'd101) begin errors++; $display("FAIL done_cnt_frozen: got %0d want 101", cycle_cnt0); end
        checks++; if (bus0.con_valid !== 1'b0) begin errors++; $display("FAIL done_con_ignored: got %b want 0", bus0.con_valid); end
    endtask

    task automatic test_exit_code();
        int hold;
        apply_reset();
        release_run(hold);
        tick();
        bus0.mem_we = 1'b1; bus0.mem_addr = TOHOST; bus0.mem_wdata = 32'h2;
        tick();
        idle_bus();
        tick();
        checks++; if (done0 !== 1'b0 || cpu_rst0 !== 1'b0) begin errors++; $display("FAIL even_write_ignored: got done %b cpu_rst %b want 0 0", done0, cpu_rst0); end
        bus0.mem_we = 1'b1; bus0.mem_addr = TOHOST; bus0.mem_wdata = 32'h7;
        tick();
        idle_bus();
        checks++; if ({done0, pass0, timeout0} !== 3'b100) begin errors++; $display("FAIL fail_flags: got %b want 100", {done0, pass0, timeout0}); end
        checks++; if (exit_code0 !== 31'd3) begin errors++; $display("FAIL fail_exit_code: got %0h want 3", exit_code0); end
    endtask

    task automatic test_timeout();
        int hold;
        apply_reset();
        release_run(hold);
        for (int i = 0; i < 200 && !done1; i++) tick();
        checks++; if ({done1, pass1, timeout1, cpu_rst1} !== 4'b1011) begin errors++; $display("FAIL to_flags: got %b want 1011", {done1, pass1, timeout1, cpu_rst1}); end
        checks++; if (cycle_cnt1 !== 32'd50) begin errors++; $display("FAIL to_cnt: got %0d want 50", cycle_cnt1); end
        tick(); tick();
        checks++; if (cycle_cnt1 !== 32'd50 || timeout1 !== 1'b1) begin errors++; $display("FAIL to_terminal: got cnt %0d to %b want 50 1", cycle_cnt1, timeout1); end
        // Terminating write in the last RUN cycle takes priority.
        apply_reset();
        release_run(hold);
        for (int i = 0; i < 200 && cycle_cnt1 != 32'd49; i++) tick();
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL race_pre_done: got %b want 0", done1); end
        bus1.mem_we = 1'b1; bus1.mem_addr = TOHOST; bus1.mem_wdata = 32'h1;
        tick();
        idle_bus();
        checks++; if ({done1, pass1, timeout1} !== 3'b110) begin errors++; $display("FAIL race_flags: got %b want 110", {done1, pass1, timeout1}); end
        checks++; if (cycle_cnt1 !== 32'd50 || exit_code1 !== 31'd0) begin errors++; $display("FAIL race_cnt_exit: got %0d %0h want 50 0", cycle_cnt1, exit_code1); end
    endtask

    task automatic test_console();
        int hold;
        apply_reset();
        release_run(hold);
        for (int i = 0; i < 17; i++) begin
            bus0.mem_we = 1'b1; bus0.mem_addr = CONSOLE; bus0.mem_wdata = 32'h41 + i;
            if (i < 16) exp_q.push_back(8'(8'h41 + i));
            tick();
        end
        idle_bus();
        tick();
        checks++; if (bus0.con_overflow !== 1'b1) begin errors++; $display("FAIL con_overflow_set: got %b want 1", bus0.con_overflow); end
        checks++; if (bus0.con_valid !== 1'b1 || bus0.con_data !== 8'h41) begin errors++; $display("FAIL con_head: got %b %0h want 1 41", bus0.con_valid, bus0.con_data); end
        bus0.con_ready = 1'b1;
        for (int i = 0; i < 40 && (exp_q.size() != 0 || bus0.con_valid); i++) tick();
        checks++; if (pops !== 16 || exp_q.size() != 0) begin errors++; $display("FAIL con_drain_count: got %0d pops %0d left want 16 0", pops, exp_q.size()); end
        checks++; if (bus0.con_valid !== 1'b0 || bus0.con_overflow !== 1'b1) begin errors++; $display("FAIL con_after_drain: got %b %b want 0 1", bus0.con_valid, bus0.con_overflow); end
    endtask

    task automatic test_back_to_back();
        int hold;
        apply_reset();
        release_run(hold);
        for (int i = 0; i < 16; i++) begin
            bus0.mem_we = 1'b1; bus0.mem_addr = CONSOLE; bus0.mem_wdata = 32'h61 + i;
            exp_q.push_back(8'(8'h61 + i));
            tick();
        end
        // Full FIFO: push and pop in the same cycle.
        bus0.con_ready = 1'b1;
        bus0.mem_we = 1'b1; bus0.mem_addr = CONSOLE; bus0.mem_wdata = 32'h23;
        exp_q.push_back(8'h23);
        tick();
        idle_bus();
        for (int i = 0; i < 40 && (exp_q.size() != 0 || bus0.con_valid); i++) tick();
        checks++; if (bus0.con_overflow !== 1'b0) begin errors++; $display("FAIL b2b_no_overflow: got %b want 0", bus0.con_overflow); end
        checks++; if (pops !== 17 || exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain_count: got %0d pops %0d left want 17 0", pops, exp_q.size()); end
    endtask

    task automatic test_mid_reset();
        int hold;
        apply_reset();
        release_run(hold);
        repeat (10) tick();
        bus0.mem_we = 1'b1; bus0.mem_addr = CONSOLE; bus0.mem_wdata = 32'h5a;
        tick();
        idle_bus();
        tick();
        checks++; if (bus0.con_valid !== 1'b1 || cpu_rst0 !== 1'b0) begin errors++; $display("FAIL mid_pre: got %b %b want 1 0", bus0.con_valid, cpu_rst0); end
        // Assert reset between clock edges; outputs must clear before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (cpu_rst0 !== 1'b1 || cycle_cnt0 !== 32'd0) begin errors++; $display("FAIL mid_async_core: got %b %0d want 1 0", cpu_rst0, cycle_cnt0); end
        checks++; if (bus0.con_valid !== 1'b0 || bus0.con_data !== 8'd0) begin errors++; $display("FAIL mid_async_fifo: got %b %0h want 0 0", bus0.con_valid, bus0.con_data); end
        checks++; if ({done0, pass0, timeout0} !== 3'b000) begin errors++; $display("FAIL mid_async_flags: got %b want 000", {done0, pass0, timeout0}); end
        exp_q.delete();
        @(negedge clk);
        release_run(hold);
        checks++; if (hold !== 4 || cycle_cnt0 !== 32'd0) begin errors++; $display("FAIL mid_hold_restart: got %0d %0d want 4 0", hold, cycle_cnt0); end
    endtask

    initial begin
        idle_bus();
        bus0.con_ready = 1'b0;
        bus1.con_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_pass();
        test_exit_code();
        test_timeout();
        test_console();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
